// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller:
// FSM state encoding, MDU latency defaults and a register-match helper.
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MDU_WAIT = 2'd1;
    localparam logic [1:0] ST_MDU_HOLD = 2'd2;

    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 33;
    localparam int CNT_W_DEF      = 6;

    typedef enum logic [1:0] {
        RUN      = ST_RUN,
        MDU_WAIT = ST_MDU_WAIT,
        MDU_HOLD = ST_MDU_HOLD
    } mdu_state_e;

    // True when a GPR producer feeds a source the consumer actually reads.
    // r0 is hard-wired zero and never creates a dependency.
    function automatic logic reg_match(
        input logic [4:0] dst,
        input logic [4:0] src,
        input logic       reads
    );
        return reads && (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/mdu_occ_counter.sv
// Loadable down-counter tracking remaining MDU occupancy cycles.
// Decrement saturates at zero; load has priority over decrement.
module mdu_occ_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, otherwise count down toward zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer around the id2->exc register: exceptions,
// memory stalls, MDU occupancy, load-use and branch mispredict/nullify.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       exception_req,
    input  logic       mem_stall,
    input  logic       exc_mul_start,
    input  logic       exc_div_start,
    input  logic       exc_is_load,
    input  logic [4:0] exc_w_reg_dst,
    input  logic [4:0] id2_rs,
    input  logic [4:0] id2_rt,
    input  logic       id2_reads_rs,
    input  logic       id2_reads_rt,
    input  logic       exc_mispredict,
    input  logic       exc_likely_nt,
    output logic       front_stall,
    output logic       front_flush,
    output logic       id2_exc_stall,
    output logic       id2_exc_flush,
    output logic       exc_mem_stall,
    output logic       exc_mem_flush,
    output logic       exception_flush,
    output logic       mdu_busy,
    output logic       mdu_done
);

    localparam logic [CNT_W-1:0] MUL_LOAD   = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(DIV_CYCLES - 2);
    // After completion the counter holds 1 for one RUN cycle so the
    // retired op, still flagged in exc, cannot restart the unit.
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(1);

    mdu_state_e       state_q;
    mdu_state_e       state_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    logic start;
    logic enter;
    logic completing;
    logic occupied;
    logic load_use;

    mdu_occ_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (cnt_load),
        .load_val_i(cnt_val),
        .dec_i     (1'b1),
        .cnt_o     (cnt),
        .zero_o    (cnt_zero)
    );

    assign start      = exc_mul_start | exc_div_start;
    assign enter      = (state_q == RUN) && start && cnt_zero
                        && !exception_req && !mem_stall;
    assign completing = !mem_stall
                        && (((state_q == MDU_WAIT) && cnt_zero)
                            || (state_q == MDU_HOLD));
    assign occupied   = enter || ((state_q == MDU_WAIT) && !cnt_zero);
    assign load_use   = exc_is_load
                        && (reg_match(exc_w_reg_dst, id2_rs, id2_reads_rs)
                            || reg_match(exc_w_reg_dst, id2_rt, id2_reads_rt));

    // MDU occupancy FSM next state and counter load control.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        if (exception_req) begin
            state_d  = RUN;
            cnt_load = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (enter) begin
                        state_d  = MDU_WAIT;
                        cnt_load = 1'b1;
                        cnt_val  = exc_div_start ? DIV_LOAD : MUL_LOAD;
                    end
                end
                MDU_WAIT: begin
                    if (cnt_zero) begin
                        if (!mem_stall) begin
                            state_d  = RUN;
                            cnt_load = 1'b1;
                            cnt_val  = GUARD_LOAD;
                        end else begin
                            state_d = MDU_HOLD;
                        end
                    end
                end
                MDU_HOLD: begin
                    if (!mem_stall) begin
                        state_d  = RUN;
                        cnt_load = 1'b1;
                        cnt_val  = GUARD_LOAD;
                    end
                end
                default: begin
                    state_d  = RUN;
                    cnt_load = 1'b1;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority mux: the first matching hazard row drives every output.
    always_comb begin
        front_stall     = 1'b0;
        front_flush     = 1'b0;
        id2_exc_stall   = 1'b0;
        id2_exc_flush   = 1'b0;
        exc_mem_stall   = 1'b0;
        exc_mem_flush   = 1'b0;
        exception_flush = 1'b0;
        mdu_busy        = 1'b0;
        mdu_done        = 1'b0;
        if (!rst_n) begin
            front_stall = 1'b0;
        end else if (exception_req) begin
            exception_flush = 1'b1;
        end else begin
            mdu_busy = (state_q != RUN);
            mdu_done = completing;
            if (mem_stall) begin
                front_stall   = 1'b1;
                id2_exc_stall = 1'b1;
                exc_mem_stall = 1'b1;
            end else if (occupied) begin
                front_stall   = 1'b1;
                id2_exc_stall = 1'b1;
                exc_mem_flush = 1'b1;
            end else if (load_use) begin
                front_stall   = 1'b1;
                id2_exc_flush = 1'b1;
            end else if (exc_mispredict) begin
                front_flush   = 1'b1;
                id2_exc_flush = exc_likely_nt;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with hand-computed
// expected output vectors per cycle.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    // Output vector bit positions: {FS FF IS IF MS MF EF BZ DN}
    localparam logic [8:0] B_FS = 9'h100;
    localparam logic [8:0] B_FF = 9'h080;
    localparam logic [8:0] B_IS = 9'h040;
    localparam logic [8:0] B_IF = 9'h020;
    localparam logic [8:0] B_MS = 9'h010;
    localparam logic [8:0] B_MF = 9'h008;
    localparam logic [8:0] B_EF = 9'h004;
    localparam logic [8:0] B_BZ = 9'h002;
    localparam logic [8:0] B_DN = 9'h001;
    localparam logic [8:0] O_OCC  = B_FS | B_IS | B_MF;
    localparam logic [8:0] O_MEMS = B_FS | B_IS | B_MS;

    logic       clk;
    logic       rst_n;
    logic       exception_req;
    logic       mem_stall;
    logic       exc_mul_start;
    logic       exc_div_start;
    logic       exc_is_load;
    logic [4:0] exc_w_reg_dst;
    logic [4:0] id2_rs;
    logic [4:0] id2_rt;
    logic       id2_reads_rs;
    logic       id2_reads_rt;
    logic       exc_mispredict;
    logic       exc_likely_nt;
    logic       front_stall;
    logic       front_flush;
    logic       id2_exc_stall;
    logic       id2_exc_flush;
    logic       exc_mem_stall;
    logic       exc_mem_flush;
    logic       exception_flush;
    logic       mdu_busy;
    logic       mdu_done;
    logic [8:0] outs;

    int n_chk;
    int n_fail;

    pipe_hazard_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .exception_req  (exception_req),
        .mem_stall      (mem_stall),
        .exc_mul_start  (exc_mul_start),
        .exc_div_start  (exc_div_start),
        .exc_is_load    (exc_is_load),
        .exc_w_reg_dst  (exc_w_reg_dst),
        .id2_rs         (id2_rs),
        .id2_rt         (id2_rt),
        .id2_reads_rs   (id2_reads_rs),
        .id2_reads_rt   (id2_reads_rt),
        .exc_mispredict (exc_mispredict),
        .exc_likely_nt  (exc_likely_nt),
        .front_stall    (front_stall),
        .front_flush    (front_flush),
        .id2_exc_stall  (id2_exc_stall),
        .id2_exc_flush  (id2_exc_flush),
        .exc_mem_stall  (exc_mem_stall),
        .exc_mem_flush  (exc_mem_flush),
        .exception_flush(exception_flush),
        .mdu_busy       (mdu_busy),
        .mdu_done       (mdu_done)
    );

    assign outs = {front_stall, front_flush, id2_exc_stall,
                   id2_exc_flush, exc_mem_stall, exc_mem_flush,
                   exception_flush, mdu_busy, mdu_done};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with inputs set: check outputs, advance a cycle.
    task automatic cyc(input string tag, input logic [8:0] exp);
        #1;
        chk(tag, 32'(outs), 32'(exp));
        @(negedge clk);
    endtask

    task automatic clr();
        exception_req  = 1'b0;
        mem_stall      = 1'b0;
        exc_mul_start  = 1'b0;
        exc_div_start  = 1'b0;
        exc_is_load    = 1'b0;
        exc_w_reg_dst  = 5'd0;
        id2_rs         = 5'd0;
        id2_rt         = 5'd0;
        id2_reads_rs   = 1'b0;
        id2_reads_rt   = 1'b0;
        exc_mispredict = 1'b0;
        exc_likely_nt  = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        clr();
        @(negedge clk);
        cyc("reset_outs", 9'h0);
        chk("reset_state", 32'(dut.state_q), 32'(ST_RUN));
        rst_n = 1'b1;
        @(negedge clk);

        // DIV with memory idle: 32 stall cycles, done in cycle 33
        exc_div_start = 1'b1;
        cyc("div_enter", O_OCC);
        for (int c = 2; c <= 32; c++) begin
            cyc("div_wait", O_OCC | B_BZ);
        end
        cyc("div_done", B_BZ | B_DN);
        cyc("div_guard", 9'h0);
        exc_div_start = 1'b0;
        cyc("div_idle", 9'h0);

        // Reset asserted mid-DIV with cnt=20
        exc_div_start = 1'b1;
        cyc("rdiv_enter", O_OCC);
        for (int c = 2; c <= 12; c++) begin
            cyc("rdiv_wait", O_OCC | B_BZ);
        end
        chk("rdiv_cnt20", 32'(dut.cnt), 32'd20);
        rst_n = 1'b0;
        exc_div_start = 1'b0;
        cyc("rst_mid", 9'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_state", 32'(dut.state_q), 32'(ST_RUN));
        chk("rst_cnt", 32'(dut.cnt), 32'd0);
        cyc("rst_after", 9'h0);

        // Load-use on rt, then r0 destination, then rs path
        exc_is_load   = 1'b1;
        exc_w_reg_dst = 5'd5;
        id2_rt        = 5'd5;
        id2_reads_rt  = 1'b1;
        id2_rs        = 5'd3;
        id2_reads_rs  = 1'b1;
        cyc("lu_rt", B_FS | B_IF);
        exc_is_load = 1'b0;
        cyc("lu_bubble", 9'h0);
        exc_is_load   = 1'b1;
        exc_w_reg_dst = 5'd0;
        id2_rt        = 5'd0;
        cyc("lu_r0", 9'h0);
        exc_w_reg_dst = 5'd7;
        id2_rs        = 5'd7;
        cyc("lu_rs", B_FS | B_IF);
        id2_reads_rs = 1'b0;
        cyc("lu_rs_unread", 9'h0);
        clr();

        // MUL reaching cnt==0 under a 3-cycle mem stall
        exc_mul_start = 1'b1;
        cyc("mul_enter", O_OCC);
        cyc("mul_w2", O_OCC | B_BZ);
        cyc("mul_w1", O_OCC | B_BZ);
        mem_stall = 1'b1;
        cyc("mul_w0_ms", O_MEMS | B_BZ);
        chk("mul_hold_st", 32'(dut.state_q), 32'(ST_MDU_HOLD));
        cyc("mul_hold1", O_MEMS | B_BZ);
        cyc("mul_hold2", O_MEMS | B_BZ);
        mem_stall = 1'b0;
        cyc("mul_hold_done", B_BZ | B_DN);
        exc_mul_start = 1'b0;
        cyc("mul_idle", 9'h0);

        // Exception during MDU_WAIT with mem stall
        exc_div_start = 1'b1;
        cyc("exc_enter", O_OCC);
        cyc("exc_wait", O_OCC | B_BZ);
        exception_req = 1'b1;
        mem_stall     = 1'b1;
        cyc("exc_flush", B_EF);
        clr();
        #1;
        chk("exc_state", 32'(dut.state_q), 32'(ST_RUN));
        cyc("exc_after", 9'h0);

        // Mispredict with and without likely-not-taken
        exc_mispredict = 1'b1;
        exc_likely_nt  = 1'b1;
        cyc("mp_likely", B_FF | B_IF);
        exc_likely_nt = 1'b0;
        cyc("mp_plain", B_FF);
        exc_mispredict = 1'b0;
        exc_likely_nt  = 1'b1;
        cyc("likely_only", 9'h0);
        exc_likely_nt  = 1'b0;
        exc_mispredict = 1'b1;
        exc_is_load    = 1'b1;
        exc_w_reg_dst  = 5'd9;
        id2_rs         = 5'd9;
        id2_reads_rs   = 1'b1;
        cyc("mp_vs_lu", B_FS | B_IF);
        clr();

        // Mispredict held through MUL, honoured on completion
        exc_mul_start  = 1'b1;
        exc_mispredict = 1'b1;
        exc_likely_nt  = 1'b1;
        cyc("mpm_enter", O_OCC);
        cyc("mpm_w2", O_OCC | B_BZ);
        cyc("mpm_w1", O_OCC | B_BZ);
        cyc("mpm_done", B_BZ | B_DN | B_FF | B_IF);
        clr();
        cyc("mpm_idle", 9'h0);

        // Mem stall alone in RUN
        mem_stall = 1'b1;
        cyc("mem_only", O_MEMS);
        clr();

        // MUL and DIV together: DIV latency is loaded
        exc_mul_start = 1'b1;
        exc_div_start = 1'b1;
        cyc("both_enter", O_OCC);
        #1;
        chk("both_cnt", 32'(dut.cnt), 32'(DIV_CYCLES_DEF - 2));
        @(negedge clk);
        exception_req = 1'b1;
        cyc("both_abort", B_EF);
        clr();
        cyc("both_idle", 9'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
